chan_flag_pipe: RTL and testbench

//  Parametrised multi-channel input capture block.
//  - Synchronises CH asynchronous inputs and detects rising edges.
//  - Produces one registered status flag per channel, using a per-channel runtime mode: pass, invert, sticky or toggle.
//  - Keeps a saturating rising-edge counter per channel.
//  - Sits between raw control/status pins and register-mapped logic, replacing ad-hoc single-bit capture flops.
//

---
 rtl/chan_flag_pkg.sv | 14 +
 rtl/chan_flag_pipe_if.sv | 15 +
 rtl/chan_flag_cell.sv | 86 ++++++++
 rtl/chan_flag_pipe.sv | 41 ++++
 tb/tb_chan_flag_pipe.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/chan_flag_pkg.sv
// rtl/chan_flag_pkg.sv - shared types and limits for the channel flag capture block
package chan_flag_pkg;

    typedef enum logic [1:0] {
        MODE_PASS   = 2'b00,
        MODE_INV    = 2'b01,
        MODE_STICKY = 2'b10,
        MODE_TOGGLE = 2'b11
    } mode_e;

    localparam int SYNC_STAGES_MAX = 4;
    localparam int CH_MAX          = 32;

endpackage

// File: rtl/chan_flag_pipe_if.sv
// rtl/chan_flag_pipe_if.sv - pin-side and status-side signal bundle for chan_flag_pipe
interface chan_flag_pipe_if #(
    parameter int CH    = 4,
    parameter int CNT_W = 4
);
    logic [CH-1:0]       IN;
    logic [2*CH-1:0]     MODE;
    logic [CH-1:0]       CLR;
    logic [CH-1:0]       FLAG;
    logic [CH*CNT_W-1:0] CNT;
    logic                ANY;

    modport master (output IN, MODE, CLR, input FLAG, CNT, ANY);
    modport slave  (input IN, MODE, CLR, output FLAG, CNT, ANY);
endinterface

// File: rtl/chan_flag_cell.sv
// rtl/chan_flag_cell.sv - one channel: synchroniser, rise detector, flag FSM, saturating counter
module chan_flag_cell
    import chan_flag_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_in,
    input  mode_e            i_mode,
    input  logic             i_clr,
    output logic             o_flag,
    output logic [CNT_W-1:0] o_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sd;
    logic                   r_flag;
    logic [CNT_W-1:0]       r_cnt;
    logic                   w_s;
    logic                   w_rise;
    logic                   w_flag_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;

    // Shift form keeps SYNC_STAGES=1 legal without a special case.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_sync <= '0;
            r_sd   <= 1'b0;
        end else begin
            r_sync <= (r_sync << 1) | SYNC_STAGES'(i_in);
            r_sd   <= w_s;
        end
    end

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_rise = w_s & ~r_sd;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_flag <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_flag <= w_flag_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    // A rise always beats a same-cycle clear so no edge is ever dropped.
    always_comb begin
        w_flag_nxt = r_flag;
        case (i_mode)
            MODE_PASS:   w_flag_nxt = w_s;
            MODE_INV:    w_flag_nxt = ~w_s;
            MODE_STICKY: begin
                if (w_rise)     w_flag_nxt = 1'b1;
                else if (i_clr) w_flag_nxt = 1'b0;
            end
            MODE_TOGGLE: begin
                if (w_rise)     w_flag_nxt = ~r_flag;
                else if (i_clr) w_flag_nxt = 1'b0;
            end
            default:     w_flag_nxt = r_flag;
        endcase
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_rise && i_clr) begin
            w_cnt_nxt = CNT_W'(1);
        end else if (w_rise) begin
            if (r_cnt != CNT_MAX) w_cnt_nxt = r_cnt + CNT_W'(1);
        end else if (i_clr) begin
            w_cnt_nxt = '0;
        end
    end

    always_comb begin
        o_flag = r_flag;
        o_cnt  = r_cnt;
    end

endmodule

// File: rtl/chan_flag_pipe.sv
// rtl/chan_flag_pipe.sv - multi-channel input capture with per-channel flag modes and edge counters
module chan_flag_pipe
    import chan_flag_pkg::*;
#(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic            CLK,
    input  logic            RST,
    chan_flag_pipe_if.slave bus
);

    if (CH < 1 || CH > CH_MAX || SYNC_STAGES < 1 || SYNC_STAGES > SYNC_STAGES_MAX ||
        CNT_W < 2 || CNT_W > 16) begin : g_bad_param
        $error("chan_flag_pipe: parameter out of range");
    end

    logic [CH-1:0]       w_flag;
    logic [CH*CNT_W-1:0] w_cnt;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        chan_flag_cell #(
            .SYNC_STAGES(SYNC_STAGES),
            .CNT_W      (CNT_W)
        ) u_cell (
            .CLK   (CLK),
            .RST   (RST),
            .i_in  (bus.IN[i]),
            .i_mode(mode_e'(bus.MODE[2*i+1 -: 2])),
            .i_clr (bus.CLR[i]),
            .o_flag(w_flag[i]),
            .o_cnt (w_cnt[i*CNT_W +: CNT_W])
        );
    end

    assign bus.FLAG = w_flag;
    assign bus.CNT  = w_cnt;
    assign bus.ANY  = |w_flag;

endmodule

// File: tb/tb_chan_flag_pipe.sv
// tb/tb_chan_flag_pipe.sv - self-checking bench for chan_flag_pipe (CH=4, SYNC_STAGES=2, CNT_W=4)
module tb_chan_flag_pipe;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    chan_flag_pipe_if #(.CH(4), .CNT_W(4)) bus ();

    chan_flag_pipe #(.CH(4), .SYNC_STAGES(2), .CNT_W(4)) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    typedef struct {
        logic [3:0]  in;
        logic [7:0]  mode;
        logic [3:0]  clr;
        logic [3:0]  flag;
        logic [15:0] cnt;
    } vec_t;

    typedef struct {
        logic [3:0]  flag;
        logic [15:0] cnt;
    } exp_t;

    vec_t vecs [22];
    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time %0t exceeded limit 100000", $time);
        $fatal(1);
    end

    initial begin
        exp_t e;

        // ch0 PASS then INV, ch1 STICKY, ch2 TOGGLE, ch3 STICKY
        vecs[0]  = '{4'h1, 8'hB8, 4'h0, 4'h0, 16'h0000};
        vecs[1]  = '{4'h1, 8'hB8, 4'h0, 4'h0, 16'h0000};
        vecs[2]  = '{4'h1, 8'hB8, 4'h0, 4'h1, 16'h0001};
        vecs[3]  = '{4'h1, 8'hB9, 4'h0, 4'h0, 16'h0001};
        vecs[4]  = '{4'h3, 8'hB9, 4'h0, 4'h0, 16'h0001};
        vecs[5]  = '{4'h3, 8'hB9, 4'h0, 4'h0, 16'h0001};
        vecs[6]  = '{4'h3, 8'hB9, 4'h0, 4'h2, 16'h0011};
        vecs[7]  = '{4'h1, 8'hB9, 4'h0, 4'h2, 16'h0011};
        vecs[8]  = '{4'h1, 8'hB9, 4'h0, 4'h2, 16'h0011};
        vecs[9]  = '{4'h1, 8'hB9, 4'h0, 4'h2, 16'h0011};
        vecs[10] = '{4'h1, 8'hB9, 4'h2, 4'h0, 16'h0001};
        vecs[11] = '{4'h1, 8'hB9, 4'h0, 4'h0, 16'h0001};
        vecs[12] = '{4'h5, 8'hB9, 4'h0, 4'h0, 16'h0001};
        vecs[13] = '{4'h1, 8'hB9, 4'h0, 4'h0, 16'h0001};
        vecs[14] = '{4'h1, 8'hB9, 4'h0, 4'h4, 16'h0101};
        vecs[15] = '{4'h5, 8'hB9, 4'h0, 4'h4, 16'h0101};
        vecs[16] = '{4'h1, 8'hB9, 4'h0, 4'h4, 16'h0101};
        vecs[17] = '{4'h1, 8'hB9, 4'h0, 4'h0, 16'h0201};
        vecs[18] = '{4'h5, 8'hB9, 4'h0, 4'h0, 16'h0201};
        vecs[19] = '{4'h1, 8'hB9, 4'h0, 4'h0, 16'h0201};
        vecs[20] = '{4'h1, 8'hB9, 4'h0, 4'h4, 16'h0301};
        vecs[21] = '{4'h1, 8'hB9, 4'h0, 4'h4, 16'h0301};

        bus.IN   = 4'h0;
        bus.MODE = 8'h00;
        bus.CLR  = 4'h0;
        rst      = 1'b0;
        tick();
        tick();
        chk("reset_flag", 32'(bus.FLAG), 32'h0);
        chk("reset_cnt",  32'(bus.CNT),  32'h0);
        chk("reset_any",  32'(bus.ANY),  32'h0);

        // Build FLAG=F, CNT=5555, then reset asynchronously mid-cycle
        rst      = 1'b1;
        bus.MODE = 8'h55;
        for (int p = 0; p < 5; p++) begin
            bus.IN = 4'hF;
            tick();
            bus.IN = 4'h0;
            tick();
        end
        tick();
        tick();
        tick();
        chk("pre_reset_flag", 32'(bus.FLAG), 32'hF);
        chk("pre_reset_cnt",  32'(bus.CNT),  32'h5555);
        #3;
        rst = 1'b0;
        #1;
        chk("async_reset_flag", 32'(bus.FLAG), 32'h0);
        chk("async_reset_cnt",  32'(bus.CNT),  32'h0);
        chk("async_reset_any",  32'(bus.ANY),  32'h0);
        tick();
        rst = 1'b1;

        for (int i = 0; i < 22; i++) begin
            bus.IN   = vecs[i].in;
            bus.MODE = vecs[i].mode;
            bus.CLR  = vecs[i].clr;
            sb.push_back('{vecs[i].flag, vecs[i].cnt});
            tick();
            e = sb.pop_front();
            chk($sformatf("vec%0d_flag", i), 32'(bus.FLAG), 32'(e.flag));
            chk($sformatf("vec%0d_cnt", i),  32'(bus.CNT),  32'(e.cnt));
            chk($sformatf("vec%0d_any", i),  32'(bus.ANY),  32'(e.flag != 4'h0));
        end

        // ch3 saturation, then a clear landing on a rise
        bus.CLR = 4'h0;
        for (int p = 0; p < 20; p++) begin
            bus.IN = 4'h9;
            tick();
            bus.IN = 4'h1;
            tick();
        end
        tick();
        tick();
        tick();
        chk("sat_cnt3",  32'(bus.CNT[15:12]), 32'd15);
        chk("sat_flag3", 32'(bus.FLAG[3]),    32'd1);
        for (int p = 0; p < 4; p++) begin
            bus.IN = 4'h9;
            tick();
            bus.IN = 4'h1;
            tick();
        end
        tick();
        tick();
        tick();
        chk("sat_hold_cnt3", 32'(bus.CNT[15:12]), 32'd15);
        bus.IN = 4'h9;
        tick();
        tick();
        bus.CLR = 4'h8;
        tick();
        bus.CLR = 4'h0;
        chk("rise_clr_cnt3", 32'(bus.CNT[15:12]), 32'd1);
        chk("rise_clr_flag", 32'(bus.FLAG),       32'hC);
        chk("other_cnts",    32'(bus.CNT[11:0]),  32'h301);

        // IN[0] held high through reset: exactly one rise after release
        bus.IN = 4'h1;
        rst    = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        chk("hold_rst_cnt0_e2", 32'(bus.CNT[3:0]), 32'd0);
        tick();
        chk("hold_rst_cnt0_e3", 32'(bus.CNT[3:0]), 32'd1);
        for (int k = 0; k < 5; k++) tick();
        chk("hold_rst_cnt0_late", 32'(bus.CNT[3:0]), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
